// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Purpose  : Owns the word-indexed PC of the instruction-fetch stage and
//             drives the instruction-memory address and fetch enable.
//             Arbitrates, in priority order, between branch/jump redirects,
//             halt requests, hazard stalls and sequential fetch. Also drives
//             the IF/ID valid bit and a one-cycle IF/ID flush pulse.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock              in   1    system clock, rising edge
//    reset              in   1    synchronous, active-low reset
//    i_redirect_valid   in   1    EX/WB branch/jump taken (pulse)
//    i_redirect_pc      in   32   redirect target, sampled with valid
//    i_stall_req        in   1    hazard unit fetch hold (level)
//    i_halt_req         in   1    halt fetch
//    i_resume           in   1    leave HALT (pulse)
//    o_pc               out  32   current PC register
//    o_imem_addr        out  AW   pc[AW-1:0]
//    o_fetch_en         out  1    imem read / IF_ID load enable
//    o_if_id_valid      out  1    IF_ID holds a real instruction
//    o_if_id_flush      out  1    one-cycle IF_ID invalidate pulse
//    o_state            out  3    FSM state (IDLE=0 RUN=1 STALL=2 FLUSH=3 HALT=4)
//  Optional (macro FETCH_SEQ_PERF_EN)
//    o_stall_cnt        out  16   cycles spent in STALL (saturating)
//    o_flush_cnt        out  16   flushing redirects accepted (saturating)
//    o_fetch_cnt        out  32   cycles with fetch enabled (saturating)
// ============================================================================
module fetch_sequencer #(
    parameter int          AW           = 5,
    parameter logic [31:0] RESET_PC     = 32'd0,
    parameter logic [31:0] PC_STEP      = 32'd1,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_redirect_valid,
    input  logic [31:0]   i_redirect_pc,
    input  logic          i_stall_req,
    input  logic          i_halt_req,
    input  logic          i_resume,
    output logic [31:0]   o_pc,
    output logic [AW-1:0] o_imem_addr,
    output logic          o_fetch_en,
    output logic          o_if_id_valid,
    output logic          o_if_id_flush,
`ifdef FETCH_SEQ_PERF_EN
    output logic [15:0]   o_stall_cnt,
    output logic [15:0]   o_flush_cnt,
    output logic [31:0]   o_fetch_cnt,
`endif
    output logic [2:0]    o_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STALL = 3'd2,
        FLUSH = 3'd3,
        HALT  = 3'd4
    } state_t;

    // Counter is loaded with FLUSH_CYCLES-1 and leaves FLUSH when it reads 0,
    // which yields exactly FLUSH_CYCLES bubble cycles.
    localparam logic [2:0] c_flush_init = 3'(FLUSH_CYCLES - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_if_id_valid;
    logic        r_if_id_flush;
    logic [2:0]  r_flush_cnt;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_valid_nxt;
    logic        w_flush_nxt;
    logic [2:0]  w_cnt_nxt;
    logic        w_fetch_en;
    logic        w_redirect_flush;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_if_id_valid <= 1'b0;
            r_if_id_flush <= 1'b0;
            r_flush_cnt   <= 3'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_if_id_valid <= w_valid_nxt;
            r_if_id_flush <= w_flush_nxt;
            r_flush_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_valid_nxt      = r_if_id_valid;
        w_flush_nxt      = 1'b0;
        w_cnt_nxt        = r_flush_cnt;
        w_fetch_en       = 1'b0;
        w_redirect_flush = 1'b0;

        case (r_state)
            IDLE: begin
                // One dead cycle after reset; a redirect here just seeds the PC.
                w_state_nxt = RUN;
                if (i_redirect_valid) begin
                    w_pc_nxt = i_redirect_pc;
                end
            end
            RUN: begin
                if (i_redirect_valid) begin
                    w_redirect_flush = 1'b1;
                end else if (i_halt_req) begin
                    w_state_nxt = HALT;
                    w_valid_nxt = 1'b0;
                end else if (i_stall_req) begin
                    // IF_ID frozen: valid bit simply held.
                    w_state_nxt = STALL;
                end else begin
                    w_fetch_en  = 1'b1;
                    w_pc_nxt    = r_pc + PC_STEP;
                    w_valid_nxt = 1'b1;
                end
            end
            STALL: begin
                if (i_redirect_valid) begin
                    w_redirect_flush = 1'b1;
                end else if (i_halt_req) begin
                    w_state_nxt = HALT;
                    w_valid_nxt = 1'b0;
                end else if (!i_stall_req) begin
                    w_state_nxt = RUN;
                end
            end
            FLUSH: begin
                if (i_redirect_valid) begin
                    w_redirect_flush = 1'b1;
                end else if (r_flush_cnt == 3'd0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_cnt_nxt = r_flush_cnt - 3'd1;
                end
            end
            HALT: begin
                // Redirects while halted retarget the PC silently.
                if (i_redirect_valid) begin
                    w_pc_nxt = i_redirect_pc;
                end else if (i_resume && !i_halt_req) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_redirect_flush) begin
            w_state_nxt = FLUSH;
            w_pc_nxt    = i_redirect_pc;
            w_valid_nxt = 1'b0;
            w_flush_nxt = 1'b1;
            w_cnt_nxt   = c_flush_init;
        end
    end

    assign o_pc          = r_pc;
    assign o_imem_addr   = r_pc[AW-1:0];
    assign o_fetch_en    = w_fetch_en;
    assign o_if_id_valid = r_if_id_valid;
    assign o_if_id_flush = r_if_id_flush;
    assign o_state       = r_state;

`ifdef FETCH_SEQ_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flushes;
    logic [31:0] r_fetch_cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_stall_cnt <= 16'd0;
            r_flushes   <= 16'd0;
            r_fetch_cnt <= 32'd0;
        end else begin
            if ((r_state == STALL) && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_redirect_flush && (r_flushes != 16'hFFFF)) begin
                r_flushes <= r_flushes + 16'd1;
            end
            if (w_fetch_en && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flushes;
    assign o_fetch_cnt = r_fetch_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_sequencer
//  Purpose  : Directed and randomized checks of fetch_sequencer against a
//             cycle-level behavioural model of the fetch rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int          AW   = 5;
    localparam int          NBUB = 2;
    localparam logic [31:0] STEP = 32'd1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          rv    = 1'b0;
    logic [31:0]   rpc   = 32'd0;
    logic          stall = 1'b0;
    logic          halt  = 1'b0;
    logic          resume = 1'b0;
    logic [31:0]   pc;
    logic [AW-1:0] imem_addr;
    logic          fetch_en;
    logic          if_id_valid;
    logic          if_id_flush;
    logic [2:0]    state;
`ifdef FETCH_SEQ_PERF_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   flush_cnt;
    logic [31:0]   fetch_cnt;
`endif

    always #5 clock = ~clock;

    fetch_sequencer dut (
        .clock            (clock),
        .reset            (reset),
        .i_redirect_valid (rv),
        .i_redirect_pc    (rpc),
        .i_stall_req      (stall),
        .i_halt_req       (halt),
        .i_resume         (resume),
        .o_pc             (pc),
        .o_imem_addr      (imem_addr),
        .o_fetch_en       (fetch_en),
        .o_if_id_valid    (if_id_valid),
        .o_if_id_flush    (if_id_flush),
`ifdef FETCH_SEQ_PERF_EN
        .o_stall_cnt      (stall_cnt),
        .o_flush_cnt      (flush_cnt),
        .o_fetch_cnt      (fetch_cnt),
`endif
        .o_state          (state)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: mode names follow the debug encoding of the state port.
    int          m_mode  = 0;    // 0 idle,1 run,2 stall,3 flush,4 halt
    logic [31:0] m_pc    = 32'd0;
    logic        m_valid = 1'b0;
    logic        m_flush = 1'b0;
    int          m_bubbles_left = 0;
    bit          m_known = 1'b0;
    longint      m_stalls = 0;
    longint      m_flushes = 0;
    longint      m_fetches = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_fetch_now();
        return (m_mode == 1) && !rv && !halt && !stall;
    endfunction

    task automatic m_take_redirect();
        m_pc = rpc;
        m_mode = 3;
        m_bubbles_left = NBUB;
        m_valid = 1'b0;
        m_flush = 1'b1;
        m_flushes++;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic m_advance();
        bit f;
        f = m_fetch_now();
        if (!reset) begin
            m_mode = 0; m_pc = 32'd0; m_valid = 1'b0; m_flush = 1'b0;
            m_bubbles_left = 0; m_stalls = 0; m_flushes = 0; m_fetches = 0;
            m_known = 1'b1;
            return;
        end
        if (m_mode == 2) m_stalls++;
        if (f) m_fetches++;
        m_flush = 1'b0;
        if (m_mode == 0) begin
            if (rv) m_pc = rpc;
            m_mode = 1;
        end else if (m_mode == 4) begin
            if (rv) m_pc = rpc;
            else if (resume && !halt) m_mode = 1;
        end else if (rv) begin
            m_take_redirect();
        end else if (m_mode == 3) begin
            m_bubbles_left--;
            if (m_bubbles_left == 0) m_mode = 1;
        end else if (halt) begin
            m_mode = 4;
            m_valid = 1'b0;
        end else if (stall) begin
            m_mode = 2;
        end else if (m_mode == 2) begin
            m_mode = 1;
        end else begin
            m_pc = m_pc + STEP;
            m_valid = 1'b1;
        end
    endtask

    function automatic logic [31:0] sat(input longint v, input longint maxv);
        return (v > maxv) ? 32'(maxv) : 32'(v);
    endfunction

    // Apply one cycle of inputs, compare everything against the model, clock.
    task automatic step(input logic rst_n, input logic r_v, input logic [31:0] r_pc,
                        input logic st, input logic ht, input logic rs);
        reset = rst_n; rv = r_v; rpc = r_pc; stall = st; halt = ht; resume = rs;
        #3;
        if (m_known) begin
            chk("pc",        pc,                         m_pc);
            chk("imem_addr", {27'd0, imem_addr},         m_pc % (32'd1 << AW));
            chk("fetch_en",  {31'd0, fetch_en},          {31'd0, m_fetch_now()});
            chk("valid",     {31'd0, if_id_valid},       {31'd0, m_valid});
            chk("flush",     {31'd0, if_id_flush},       {31'd0, m_flush});
            chk("state",     {29'd0, state},             32'(m_mode));
`ifdef FETCH_SEQ_PERF_EN
            chk("stall_cnt", {16'd0, stall_cnt},         sat(m_stalls, 65535));
            chk("flush_cnt", {16'd0, flush_cnt},         sat(m_flushes, 65535));
            chk("fetch_cnt", fetch_cnt,                  sat(m_fetches, 64'hFFFF_FFFF));
`endif
        end
        m_advance();
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] fetch_base;
`endif

    initial begin
        #1;
        // Reset for two cycles, then sequential fetch.
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_pc",    pc,                   32'd0);
        chk("rst_state", {29'd0, state},       32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        run(4);
        chk("t1_pc3",    pc,                   32'd3);
        chk("t1_valid",  {31'd0, if_id_valid}, 32'd1);

        // Redirect at pc=10 to 3: flush pulse, two bubbles, then fetch at 3.
        run(7);
        chk("t2_pc10",   pc,                   32'd10);
        step(1'b1, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
        chk("t2_pc3",    pc,                   32'd3);
        chk("t2_flush",  {31'd0, if_id_flush}, 32'd1);
        run(2);
        chk("t2_fetch",  {31'd0, fetch_en},    32'd1);
        chk("t2_addr",   {27'd0, imem_addr},   32'd3);

        // Stall three cycles at pc=5; first fetch after release is at 5.
        run(2);
        chk("t3_pc5",    pc,                   32'd5);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("t3_hold",   pc,                   32'd5);
        chk("t3_valid",  {31'd0, if_id_valid}, 32'd1);
        run(1);
        chk("t3_addr5",  {27'd0, imem_addr},   32'd5);
        chk("t3_fetch",  {31'd0, fetch_en},    32'd1);

        // Redirect beats stall and halt in the same cycle; halt after flush.
        step(1'b1, 1'b1, 32'd12, 1'b1, 1'b1, 1'b0);
        chk("t4_pc12",   pc,                   32'd12);
        chk("t4_flushst",{29'd0, state},       32'd3);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("t4_halt",   {29'd0, state},       32'd4);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        chk("t4_still",  {29'd0, state},       32'd4);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("t4_run",    {29'd0, state},       32'd1);
        chk("t4_pc",     pc,                   32'd12);

        // Reset in the middle of FLUSH.
        step(1'b1, 1'b1, 32'd20, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("t5_pc",     pc,                   32'd0);
        chk("t5_state",  {29'd0, state},       32'd0);
        chk("t5_flush",  {31'd0, if_id_flush}, 32'd0);
        run(1);

        // imem_addr wraps at 2**AW while pc keeps counting.
        step(1'b1, 1'b1, 32'd31, 1'b0, 1'b0, 1'b0);
        run(2);
`ifdef FETCH_SEQ_PERF_EN
        fetch_base = fetch_cnt;
`endif
        chk("t6_addr31", {27'd0, imem_addr},   32'd31);
        run(1);
        chk("t6_addr0",  {27'd0, imem_addr},   32'd0);
        chk("t6_pc32",   pc,                   32'd32);
        run(1);
`ifdef FETCH_SEQ_PERF_EN
        chk("t6_fcnt",   fetch_cnt - fetch_base, 32'd2);
`endif

        // pc wraps modulo 2**32.
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run(4);
        chk("wrap_pc",   pc,                   32'd1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            step(($urandom_range(0, 79) != 0),
                 ($urandom_range(0, 7) == 0),
                 tgt,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
